// File: rtl/l1_stream_pkg.sv
// Shared types for the multi-stream L1 read pointer: stream state,
// sid/clid/clofs types for the default configuration and the line
// request/response record.
package l1_stream_pkg;

   localparam int NSTREAMS_DEF = 4;
   localparam int NCL_DEF      = 16;
   localparam int CL_SIZE_DEF  = 8;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } stream_state_e;

   typedef logic [$clog2(NSTREAMS_DEF)-1:0] sid_t;
   typedef logic [$clog2(NCL_DEF)-1:0]      clid_t;
   typedef logic [$clog2(CL_SIZE_DEF)-1:0]  clofs_t;

   typedef struct packed {
      logic v;
      sid_t sid;
   } line_msg_t;

endpackage

// File: rtl/l1_stream_ctx.sv
// One stream's context: read pointer, line counters (valid, to-request,
// in-flight, not-yet-queued) and the IDLE/ACTIVE state.
module l1_stream_ctx
   import l1_stream_pkg::*;
#(
   parameter int ncl         = 16,
   parameter int cl_size     = 8,
   parameter int min_cl      = 2,
   parameter int len_width   = 16,
   parameter int nports      = 8,
   parameter int clid_width  = $clog2(ncl),
   parameter int clofs_width = $clog2(cl_size),
   parameter int width       = clid_width + clofs_width
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [clid_width-1:0]  start_clid,
   input  logic [len_width-1:0]   start_len,
   input  logic [clofs_width:0]   gcnt,
   input  logic                   req_acc,
   input  logic                   rsp,
   output logic [width-1:0]       ptr,
   output logic                   act,
   output logic                   done,
   output logic                   rd_en,
   output logic [clofs_width:0]   lim,
   output logic                   req_want,
   output logic                   nf_zero,
   output logic                   stray
);

   localparam int cw = clid_width + 1;
   localparam int gw = clofs_width + 1;

   stream_state_e state, state_n;
   logic [clid_width-1:0]  clid;
   logic [clofs_width-1:0] clofs;
   logic [cw-1:0]          nv, nq, nf, nv_n, nq_n, nf_n, start_nq;
   logic [len_width-1:0]   rem, rem_n;
   logic [gw-1:0]          ofs_sum;
   logic                   carry, rsp_ok, refill, fin, done_q;

   // Pointer advance and counter updates; an increment and decrement in the same cycle cancel
   always_comb begin
      ofs_sum  = {1'b0, clofs} + gcnt;
      carry    = ofs_sum[clofs_width];
      rsp_ok   = rsp & (nf != '0);
      refill   = carry & (rem != '0);
      nv_n     = nv + cw'(rsp_ok) - cw'(carry);
      nq_n     = nq + cw'(refill) - cw'(req_acc);
      nf_n     = nf + cw'(req_acc) - cw'(rsp_ok);
      rem_n    = rem - len_width'(refill);
      fin      = carry & (rem == '0) & (nv_n == '0);
      start_nq = (start_len >= len_width'(ncl)) ? cw'(ncl) : start_len[cw-1:0];
   end

   // Next state: a start always (re)activates, consuming the last line retires the stream
   always_comb begin
      state_n = state;
      if (start)
         state_n = ST_ACTIVE;
      else if (fin)
         state_n = ST_IDLE;
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_n;
   end

   // Pointer, counters and done pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clid   <= '0;
         clofs  <= '0;
         nv     <= '0;
         nq     <= '0;
         nf     <= '0;
         rem    <= '0;
         done_q <= 1'b0;
      end else if (start) begin
         clid   <= start_clid;
         clofs  <= '0;
         nv     <= '0;
         nq     <= start_nq;
         nf     <= '0;
         rem    <= start_len - len_width'(start_nq);
         done_q <= 1'b0;
      end else begin
         clofs  <= ofs_sum[clofs_width-1:0];
         clid   <= clid + clid_width'(carry);
         nv     <= nv_n;
         nq     <= nq_n;
         nf     <= nf_n;
         rem    <= rem_n;
         done_q <= fin;
      end
   end

   // Outputs: reads need enough buffered lines (or the final line once nothing is outstanding)
   always_comb begin
      ptr      = {clid, clofs};
      act      = (state == ST_ACTIVE);
      done     = done_q;
      nf_zero  = (nf == '0);
      stray    = rsp & (nf == '0);
      req_want = act & ~start & (nq != '0);
      rd_en    = act & ~start &
                 ((nv >= cw'(min_cl)) |
                  ((nv != '0) & (rem == '0) & (nq == '0) & (nf == '0)));
      lim      = (nv == cw'(1)) ? (gw'(cl_size) - {1'b0, clofs}) : gw'(nports);
   end

endmodule

// File: rtl/l1_mstream_ptr.sv
// Multi-stream L1 read pointer: per-stream contexts, per-port read grants
// with in-order address ranking, and a round-robin line request arbiter.
module l1_mstream_ptr
   import l1_stream_pkg::*;
#(
   parameter int nstreams    = 4,
   parameter int nports      = 8,
   parameter int ncl         = 16,
   parameter int cl_size     = 8,
   parameter int min_cl      = 2,
   parameter int len_width   = 16,
   parameter int sid_width   = $clog2(nstreams),
   parameter int clid_width  = $clog2(ncl),
   parameter int clofs_width = $clog2(cl_size),
   parameter int width       = clid_width + clofs_width
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          i_start_v,
   output logic                          i_start_r,
   input  logic [sid_width-1:0]          i_start_sid,
   input  logic [clid_width-1:0]         i_start_clid,
   input  logic [len_width-1:0]          i_start_len,
   input  logic [nports-1:0]             i_rd_v,
   output logic [nports-1:0]             i_rd_r,
   input  logic [nports*sid_width-1:0]   i_rd_sid,
   output logic [nports*width-1:0]       o_rd_d,
   output logic [nstreams*width-1:0]     o_d,
   output logic [nstreams-1:0]           o_act,
   output logic [nstreams-1:0]           o_done,
   output logic                          o_clreq_v,
   input  logic                          o_clreq_r,
   output logic [sid_width-1:0]          o_clreq_sid,
   input  logic                          i_clrsp_v,
   output logic                          i_clrsp_r,
   input  logic [sid_width-1:0]          i_clrsp_sid,
   output logic                          o_err
);

   localparam int gw = clofs_width + 1;

   logic [width-1:0]     ptr  [nstreams];
   logic [gw-1:0]        lim  [nstreams];
   logic [gw-1:0]        gcnt [nstreams];
   logic [nstreams-1:0]  rd_en, req_want, nf_zero, stray, start_hit, req_acc, rsp_hit;
   logic                 start_acc, req_found;
   logic [sid_width-1:0] prio, req_sid, psid;
   logic [gw-1:0]        rank;

   assign i_clrsp_r   = 1'b1;
   assign i_start_r   = nf_zero[i_start_sid];
   assign start_acc   = i_start_v & i_start_r;
   assign o_clreq_v   = req_found;
   assign o_clreq_sid = req_sid;

   for (genvar s = 0; s < nstreams; s++) begin : g_stream
      assign start_hit[s] = start_acc & (i_start_sid == sid_width'(s));
      assign req_acc[s]   = o_clreq_v & o_clreq_r & (req_sid == sid_width'(s));
      assign rsp_hit[s]   = i_clrsp_v & (i_clrsp_sid == sid_width'(s));
      assign o_d[s*width +: width] = ptr[s];

      l1_stream_ctx #(
         .ncl        (ncl),
         .cl_size    (cl_size),
         .min_cl     (min_cl),
         .len_width  (len_width),
         .nports     (nports),
         .clid_width (clid_width),
         .clofs_width(clofs_width),
         .width      (width)
      ) u_ctx (
         .clk       (clk),
         .reset     (reset),
         .start     (start_hit[s]),
         .start_clid(i_start_clid),
         .start_len (i_start_len),
         .gcnt      (gcnt[s]),
         .req_acc   (req_acc[s]),
         .rsp       (rsp_hit[s]),
         .ptr       (ptr[s]),
         .act       (o_act[s]),
         .done      (o_done[s]),
         .rd_en     (rd_en[s]),
         .lim       (lim[s]),
         .req_want  (req_want[s]),
         .nf_zero   (nf_zero[s]),
         .stray     (stray[s])
      );
   end

   // Port grants: lowest-index ports first, each address offset by its rank within its stream
   always_comb begin
      for (int s = 0; s < nstreams; s++)
         gcnt[s] = '0;
      i_rd_r = '0;
      o_rd_d = '0;
      psid   = '0;
      rank   = '0;
      for (int p = 0; p < nports; p++) begin
         psid = i_rd_sid[p*sid_width +: sid_width];
         rank = gcnt[psid];
         if (i_rd_v[p] && rd_en[psid] && (rank < lim[psid])) begin
            i_rd_r[p]  = 1'b1;
            gcnt[psid] = rank + gw'(1);
         end
         o_rd_d[p*width +: width] = ptr[psid] + width'(rank);
      end
   end

   // Round-robin pick among streams with lines left to request, starting at prio
   always_comb begin
      req_found = 1'b0;
      req_sid   = '0;
      for (int i = 0; i < nstreams; i++) begin
         if (!req_found && req_want[(int'(prio) + i) % nstreams]) begin
            req_found = 1'b1;
            req_sid   = sid_width'((int'(prio) + i) % nstreams);
         end
      end
   end

   // Priority moves past the stream whose request was just taken
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         prio <= '0;
      else if (o_clreq_v && o_clreq_r)
         prio <= sid_width'((int'(req_sid) + 1) % nstreams);
   end

   // Sticky error on a response to a stream with nothing in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         o_err <= 1'b0;
      else if (|stray)
         o_err <= 1'b1;
   end

endmodule

// File: tb/tb_l1_mstream_ptr.sv
// Self-checking bench for l1_mstream_ptr (4 streams, 8 ports, 16 lines,
// 8 reads per line): table-driven read vectors plus directed sequences.
module tb_l1_mstream_ptr;
   import l1_stream_pkg::*;

   localparam int NP = 8;
   localparam int W  = 7;

   logic          clk = 1'b0;
   logic          reset;
   logic          i_start_v;
   logic          i_start_r;
   sid_t          i_start_sid;
   clid_t         i_start_clid;
   logic [15:0]   i_start_len;
   logic [7:0]    i_rd_v;
   logic [7:0]    i_rd_r;
   logic [15:0]   i_rd_sid;
   logic [55:0]   o_rd_d;
   logic [27:0]   o_d;
   logic [3:0]    o_act;
   logic [3:0]    o_done;
   logic          o_clreq_v;
   logic          o_clreq_r;
   sid_t          o_clreq_sid;
   logic          i_clrsp_v;
   logic          i_clrsp_r;
   sid_t          i_clrsp_sid;
   logic          o_err;

   int n_compared   = 0;
   int n_mismatched = 0;

   typedef struct {
      logic [7:0]  rd_v;
      logic [15:0] rd_sid;
      logic [7:0]  exp_rd_r;
      logic [6:0]  exp_base;
   } rd_vec_t;

   rd_vec_t vecs [6];

   l1_mstream_ptr dut (
      .clk         (clk),
      .reset       (reset),
      .i_start_v   (i_start_v),
      .i_start_r   (i_start_r),
      .i_start_sid (i_start_sid),
      .i_start_clid(i_start_clid),
      .i_start_len (i_start_len),
      .i_rd_v      (i_rd_v),
      .i_rd_r      (i_rd_r),
      .i_rd_sid    (i_rd_sid),
      .o_rd_d      (o_rd_d),
      .o_d         (o_d),
      .o_act       (o_act),
      .o_done      (o_done),
      .o_clreq_v   (o_clreq_v),
      .o_clreq_r   (o_clreq_r),
      .o_clreq_sid (o_clreq_sid),
      .i_clrsp_v   (i_clrsp_v),
      .i_clrsp_r   (i_clrsp_r),
      .i_clrsp_sid (i_clrsp_sid),
      .o_err       (o_err)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearInputs();
      i_start_v    = 1'b0;
      i_start_sid  = '0;
      i_start_clid = '0;
      i_start_len  = '0;
      i_rd_v       = '0;
      i_rd_sid     = '0;
      o_clreq_r    = 1'b0;
      i_clrsp_v    = 1'b0;
      i_clrsp_sid  = '0;
   endtask

   task automatic resetDut();
      reset = 1'b1;
      clearInputs();
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Drive one read vector, then check grants and each granted port's address
   task automatic applyStimulus(input int i);
      int         rank_cnt;
      logic [6:0] exp_d;
      i_rd_v   = vecs[i].rd_v;
      i_rd_sid = vecs[i].rd_sid;
      #1;
      checkOutput($sformatf("vec%0d_rd_r", i), i_rd_r, vecs[i].exp_rd_r);
      rank_cnt = 0;
      for (int p = 0; p < NP; p++) begin
         if (vecs[i].exp_rd_r[p]) begin
            exp_d = vecs[i].exp_base + 7'(rank_cnt);
            checkOutput($sformatf("vec%0d_rd_d%0d", i, p), o_rd_d[p*W +: W], exp_d);
            rank_cnt++;
         end
      end
   endtask

   // Stream 1 from line 3, four lines: all four lines fit, so all are requested up front
   task automatic runScenarioA(input string tag);
      i_start_v    = 1'b1;
      i_start_sid  = 2'd1;
      i_start_clid = 4'd3;
      i_start_len  = 16'd4;
      #1;
      checkOutput({tag, "_start_r"}, i_start_r, 1);
      tick();
      i_start_v = 1'b0;
      checkOutput({tag, "_act"}, o_act, 4'b0010);
      checkOutput({tag, "_ptr_start"}, o_d[1*W +: W], 7'd24);
      i_rd_v    = 8'hff;
      i_rd_sid  = 16'h5555;
      o_clreq_r = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         checkOutput($sformatf("%s_req%0d", tag, k), {o_clreq_v, o_clreq_sid}, 3'b101);
         checkOutput($sformatf("%s_rd_blocked%0d", tag, k), i_rd_r, 8'h00);
         tick();
      end
      o_clreq_r = 1'b0;
      #1;
      checkOutput({tag, "_req_drained"}, o_clreq_v, 0);
      i_clrsp_v   = 1'b1;
      i_clrsp_sid = 2'd1;
      tick();
      checkOutput({tag, "_rd_one_line"}, i_rd_r, 8'h00);
      tick();
      i_clrsp_v = 1'b0;
      applyStimulus(0);
      tick();
      checkOutput({tag, "_ptr_next"}, o_d[1*W +: W], 7'd32);
      checkOutput({tag, "_still_act"}, o_act, 4'b0010);
      checkOutput({tag, "_rd_wait_inflight"}, i_rd_r, 8'h00);
      clearInputs();
   endtask

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: run exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main test sequence
   initial begin
      logic [1:0] exp_seq [4];
      exp_seq = '{2'd0, 2'd2, 2'd3, 2'd0};

      vecs[0] = '{rd_v: 8'hff, rd_sid: 16'h5555, exp_rd_r: 8'hff, exp_base: 7'd24};
      vecs[1] = '{rd_v: 8'h01, rd_sid: 16'hAAAA, exp_rd_r: 8'h01, exp_base: 7'd56};
      vecs[2] = '{rd_v: 8'hff, rd_sid: 16'h8888, exp_rd_r: 8'hAA, exp_base: 7'd57};
      vecs[3] = '{rd_v: 8'hff, rd_sid: 16'hAAAA, exp_rd_r: 8'h07, exp_base: 7'd61};
      vecs[4] = '{rd_v: 8'hff, rd_sid: 16'hAAAA, exp_rd_r: 8'h00, exp_base: 7'd0};
      vecs[5] = '{rd_v: 8'hff, rd_sid: 16'hFFFF, exp_rd_r: 8'hff, exp_base: 7'd120};

      reset = 1'b1;
      clearInputs();
      tick();
      tick();
      checkOutput("rst_act", o_act, 4'b0000);
      checkOutput("rst_start_r", i_start_r, 1);
      checkOutput("rst_clreq_v", o_clreq_v, 0);
      checkOutput("rst_err", o_err, 0);
      checkOutput("rst_done", o_done, 4'b0000);
      checkOutput("rst_ptrs", o_d, 28'd0);
      reset = 1'b0;

      runScenarioA("a1");

      // Restart suppression and round-robin order over streams 0, 2, 3
      resetDut();
      i_start_v    = 1'b1;
      i_start_sid  = 2'd0;
      i_start_clid = 4'd0;
      i_start_len  = 16'd2;
      tick();
      i_start_clid = 4'd5;
      #1;
      checkOutput("b_restart_r", i_start_r, 1);
      checkOutput("b_req_suppressed", o_clreq_v, 0);
      tick();
      checkOutput("b_restart_ptr", o_d[0*W +: W], 7'd40);
      i_start_sid  = 2'd2;
      i_start_clid = 4'd1;
      tick();
      i_start_sid  = 2'd3;
      tick();
      i_start_v = 1'b0;
      o_clreq_r = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         checkOutput($sformatf("b_rr%0d", k), {o_clreq_v, o_clreq_sid}, {1'b1, exp_seq[k]});
         tick();
      end
      clearInputs();

      // Single-line stream: start blocked while in flight, partial last-line grant, done, stray response
      resetDut();
      i_start_v    = 1'b1;
      i_start_sid  = 2'd2;
      i_start_clid = 4'd7;
      i_start_len  = 16'd1;
      tick();
      i_start_v = 1'b0;
      o_clreq_r = 1'b1;
      #1;
      checkOutput("c_req", {o_clreq_v, o_clreq_sid}, 3'b110);
      tick();
      o_clreq_r = 1'b0;
      #1;
      checkOutput("c_start_r_busy", i_start_r, 0);
      i_clrsp_v   = 1'b1;
      i_clrsp_sid = 2'd2;
      #1;
      checkOutput("c_start_r_busy_rsp", i_start_r, 0);
      tick();
      i_clrsp_v = 1'b0;
      checkOutput("c_start_r_free", i_start_r, 1);
      for (int i = 1; i <= 3; i++) begin
         applyStimulus(i);
         tick();
      end
      checkOutput("c_done_pulse", o_done, 4'b0100);
      checkOutput("c_idle", o_act, 4'b0000);
      checkOutput("c_ptr_after", o_d[2*W +: W], 7'd64);
      tick();
      checkOutput("c_done_clear", o_done, 4'b0000);
      applyStimulus(4);
      i_rd_v = '0;
      checkOutput("c_err_before", o_err, 0);
      i_clrsp_v   = 1'b1;
      i_clrsp_sid = 2'd2;
      tick();
      i_clrsp_v = 1'b0;
      checkOutput("c_err_set", o_err, 1);
      tick();
      checkOutput("c_err_sticky", o_err, 1);

      // Line-id wrap 15 -> 0 with a refill request for the remaining line
      i_start_v    = 1'b1;
      i_start_sid  = 2'd3;
      i_start_clid = 4'd15;
      i_start_len  = 16'd17;
      tick();
      i_start_v = 1'b0;
      o_clreq_r = 1'b1;
      for (int k = 0; k < 16; k++) begin
         #1;
         checkOutput($sformatf("d_req%0d", k), {o_clreq_v, o_clreq_sid}, 3'b111);
         tick();
      end
      o_clreq_r = 1'b0;
      #1;
      checkOutput("d_req_drained", o_clreq_v, 0);
      checkOutput("d_start_r_busy", i_start_r, 0);
      i_clrsp_v   = 1'b1;
      i_clrsp_sid = 2'd3;
      tick();
      tick();
      i_clrsp_v = 1'b0;
      applyStimulus(5);
      tick();
      checkOutput("d_wrap_ptr", o_d[3*W +: W], 7'd0);
      checkOutput("d_refill_req", {o_clreq_v, o_clreq_sid}, 3'b111);
      checkOutput("d_err_held", o_err, 1);

      // Asynchronous reset in the middle of the clock period
      #2;
      reset = 1'b1;
      #1;
      checkOutput("m_act", o_act, 4'b0000);
      checkOutput("m_done", o_done, 4'b0000);
      checkOutput("m_clreq_v", o_clreq_v, 0);
      checkOutput("m_start_r", i_start_r, 1);
      checkOutput("m_err", o_err, 0);
      checkOutput("m_ptrs", o_d, 28'd0);
      checkOutput("m_rd_r", i_rd_r, 8'h00);
      @(posedge clk);
      #1;
      reset = 1'b0;
      clearInputs();
      runScenarioA("a2");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
